// File: rtl/mem2apb_xbar.sv
// mem2apb_xbar: valid/ready memory requests to a shared APB4 bus with an
// N-way base/mask decoder, decode-miss errors, pslverr propagation and a
// sticky first-error address capture.
// Optional build macro: MEM2APB_XBAR_TIMEOUT_EN adds an ACCESS-phase watchdog
// that forces an error response after TIMEOUT_CYCLES cycles without pready.
module mem2apb_xbar #(
  parameter int                    NUM_SLV        = 8,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE       = '0,
  parameter logic [NUM_SLV*32-1:0] SLV_MASK       = '0,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [3:0]            mem_wstrb_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_ready_o,
  output logic                  mem_err_o,
  output logic [31:0]           apb_paddr_o,
  output logic [2:0]            apb_pprot_o,
  output logic [NUM_SLV-1:0]    apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [31:0]           apb_pwdata_o,
  output logic [3:0]            apb_pstrb_o,
  input  logic [NUM_SLV-1:0]    apb_pready_i,
  input  logic [NUM_SLV*32-1:0] apb_prdata_i,
  input  logic [NUM_SLV-1:0]    apb_pslverr_i,
  output logic                  err_valid_o,
  output logic [31:0]           err_addr_o,
  input  logic                  err_clr_i
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, hit_idx;
  logic             hit;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             sel_pready, sel_pslverr;
  logic [31:0]      sel_prdata;
  logic             timeout;
  logic             err_event;
  logic [31:0]      err_src;

  assign apb_pprot_o = 3'b000;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((mem_addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign sel_pready  = apb_pready_i[sel];
  assign sel_pslverr = apb_pslverr_i[sel];
  assign sel_prdata  = apb_prdata_i[32*sel +: 32];

`ifdef MEM2APB_XBAR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] to_cnt;

  // Watchdog: held at zero outside ACCESS, counts ACCESS cycles with pready low.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != ACCESS) begin
      to_cnt <= '0;
    end else if (!sel_pready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == ACCESS) && !sel_pready &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the limit has no effect; a slave may stall forever.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state logic for the IDLE/SETUP/ACCESS/RESP transfer sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_valid_i) state_nxt = hit ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (sel_pready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request capture and response capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      sel          <= '0;
      apb_paddr_o  <= '0;
      apb_pwdata_o <= '0;
      apb_pstrb_o  <= '0;
      apb_pwrite_o <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (mem_valid_i) begin
            apb_paddr_o  <= mem_addr_i;
            apb_pwdata_o <= mem_wdata_i;
            apb_pstrb_o  <= mem_wstrb_i;  // already all-zero on reads
            apb_pwrite_o <= |mem_wstrb_i;
            sel          <= hit_idx;
            rdata_q      <= '0;
            err_q        <= !hit;          // miss goes straight to RESP
          end
        end
        ACCESS: begin
          if (sel_pready) begin
            rdata_q <= apb_pwrite_o ? 32'h0 : sel_prdata;
            err_q   <= sel_pslverr;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // APB select/enable and requester response decode from the current state.
  always_comb begin
    apb_psel_o = '0;
    if (state == SETUP || state == ACCESS) apb_psel_o[sel] = 1'b1;
  end

  assign apb_penable_o = (state == ACCESS);
  assign mem_ready_o   = (state == RESP);
  assign mem_rdata_o   = (state == RESP) ? rdata_q : 32'h0;
  assign mem_err_o     = (state == RESP) && err_q;

  // Error source: a miss is known in IDLE, a slave error/timeout in ACCESS.
  assign err_event = (state == IDLE && mem_valid_i && !hit) ||
                     (state == ACCESS && ((sel_pready && sel_pslverr) || timeout));
  assign err_src   = (state == IDLE) ? mem_addr_i : apb_paddr_o;

  // Sticky first-error capture; a new error beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else if (err_event && (!err_valid_o || err_clr_i)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= err_src;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end

endmodule
